// File: rtl/aes_vp_pkg.sv
// rtl/aes_vp_pkg.sv - shared constants, FSM state type and beat-count helper for the AES verify platform
package aes_vp_pkg;

  // Width of one plaintext block as stored in the data FIFO.
  localparam int BLK_W = 128;

  // Serializer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

  // Number of bus beats needed to carry one block.
  function automatic int beats(input int bus_w);
    return BLK_W / bus_w;
  endfunction

endpackage

// File: rtl/fifo128_serializer.sv
// rtl/fifo128_serializer.sv - pops 128-bit FIFO blocks and streams them MSB-first as BUS_W-bit beats; FIFO128_SER_BLKCNT_EN adds blk_cnt
module fifo128_serializer
  import aes_vp_pkg::*;
#(
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [BUS_W-1:0] ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
`ifdef FIFO128_SER_BLKCNT_EN
  ,
  output logic [31:0]      blk_cnt
`endif
);

  localparam int BEATS = beats(BUS_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   shreg_q, shreg_d;
  logic               last_hs;

  // State, beat counter and shift register; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic; the FIFO is only popped when idle or while the last beat is taken.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    fifo_rd   = 1'b0;
    ser_valid = 1'b0;
    last_hs   = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_rd = !fifo_empty;
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        // FIFO read data is valid one cycle after the pop.
        shreg_d = fifo_data;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        ser_valid = 1'b1;
        if (ser_ready) begin
          shreg_d = shreg_q << BUS_W;
          if (cnt_q == LAST_BEAT) begin
            last_hs = 1'b1;
            cnt_d   = '0;
            fifo_rd = !fifo_empty;
            state_d = fifo_empty ? IDLE : FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A pop during reset would lose a block the FSM is about to forget.
    if (rst) fifo_rd = 1'b0;
  end

  assign ser_data  = shreg_q[BLK_W-1 -: BUS_W];
  assign ser_first = ser_valid && (cnt_q == '0);
  assign ser_last  = ser_valid && (cnt_q == LAST_BEAT);
  assign busy      = (state_q != IDLE);

`ifdef FIFO128_SER_BLKCNT_EN
  logic [31:0] blk_cnt_q;

  // Completed-block counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) blk_cnt_q <= '0;
    else if (last_hs) blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_fifo128_serializer.sv
// tb/tb_fifo128_serializer.sv - randomized self-checking bench with a beat-stream scoreboard for fifo128_serializer
module tb_fifo128_serializer;

  localparam int BUS_W = 32;
  localparam int BEATS = 128 / BUS_W;
  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic             clk = 1'b0;
  logic             rst;
  logic [127:0]     fifo_data;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [BUS_W-1:0] ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
`ifdef FIFO128_SER_BLKCNT_EN
  logic [31:0]      blk_cnt;
`endif

  always #5 clk = ~clk;

  fifo128_serializer #(.BUS_W(BUS_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .busy       (busy)
`ifdef FIFO128_SER_BLKCNT_EN
    ,
    .blk_cnt    (blk_cnt)
`endif
  );

  typedef struct packed {
    logic [BUS_W-1:0] d;
    logic             f;
    logic             l;
  } beat_t;

  logic [127:0] fifo_q[$];
  beat_t        exp_q[$];
  bit           bubble;
  int           checks;
  int           errors;
  int           rd_pulses;
  int           beats_seen;
  logic [31:0]  blk_model;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [127:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: compare DUT against the expected beat stream, then advance the FIFO and model.
  task automatic tick();
    logic  exp_rd, exp_valid, rd_s;
    beat_t e, nb;
    logic [127:0] blk;
    #1;
    exp_valid = !bubble && (exp_q.size() > 0);
    exp_rd    = !rst && !fifo_empty && !bubble &&
                (exp_q.size() == 0 || (exp_q.size() == 1 && ser_ready));
    chk("fifo_rd", fifo_rd, exp_rd);
    chk("ser_valid", ser_valid, exp_valid);
    chk("busy", busy, bubble || (exp_q.size() > 0));
    if (exp_valid) begin
      e = exp_q[0];
      chk("ser_data", ser_data, e.d);
      chk("ser_first", ser_first, e.f);
      chk("ser_last", ser_last, e.l);
    end else begin
      chk("first_idle", ser_first, 1'b0);
      chk("last_idle", ser_last, 1'b0);
    end
`ifdef FIFO128_SER_BLKCNT_EN
    chk("blk_cnt", blk_cnt, blk_model);
`endif
    if (fifo_rd) rd_pulses++;
    if (exp_valid && ser_ready) begin
      if (e.l && !rst) blk_model++;
      void'(exp_q.pop_front());
      beats_seen++;
    end
    bubble = 1'b0;
    if (exp_rd) begin
      blk = fifo_q[0];
      for (int b = 0; b < BEATS; b++) begin
        nb.d = BUS_W'(blk >> (BUS_W * (BEATS - 1 - b)));
        nb.f = (b == 0);
        nb.l = (b == BEATS - 1);
        exp_q.push_back(nb);
      end
      bubble = 1'b1;
    end
    rd_s = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    if (rst) begin
      exp_q.delete();
      bubble    = 1'b0;
      blk_model = '0;
    end
    @(negedge clk);
  endtask

  // Run until the beat with `remaining` beats left in the block is on the bus.
  task automatic wait_exp(input int remaining, input string tag);
    int k;
    k = 0;
    while (!(exp_q.size() == remaining && !bubble) && k < 50) begin
      tick();
      k++;
    end
    chk(tag, k < 50, 1'b1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0 || bubble) && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, k < 2000, 1'b1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rd_pulses  = 0;
    beats_seen = 0;
    blk_model  = '0;
    bubble     = 1'b0;
    rst        = 1'b1;
    ser_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, and no pop while reset is held even with data waiting.
    push(BLK_A);
    #1;
    chk("rst_valid", ser_valid, 1'b0);
    chk("rst_first", ser_first, 1'b0);
    chk("rst_last", ser_last, 1'b0);
    chk("rst_data", ser_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd", fifo_rd, 1'b0);
`ifdef FIFO128_SER_BLKCNT_EN
    chk("rst_blk_cnt", blk_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single known block, no backpressure.
    drain("single_done");
    chk("single_beats", beats_seen, BEATS);
    repeat (3) tick();

    // Backpressure while beat 1 is on the bus.
    push(BLK_A);
    wait_exp(BEATS - 1, "bp_reach");
    ser_ready = 1'b0;
    repeat (5) tick();
    ser_ready = 1'b1;
    drain("bp_done");

    // Three blocks queued back to back.
    rd_pulses  = 0;
    beats_seen = 0;
    for (int i = 0; i < 3; i++) push({$urandom, $urandom, $urandom, $urandom});
    drain("three_done");
    chk("three_rd_pulses", rd_pulses, 3);
    chk("three_beats", beats_seen, 3 * BEATS);

    // FIFO runs dry, then refills later.
    repeat (4) tick();
    push({$urandom, $urandom, $urandom, $urandom});
    drain("refill_done");

    // Reset in the middle of a block.
    push({$urandom, $urandom, $urandom, $urandom});
    wait_exp(BEATS - 2, "mid_rst_reach");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    push(BLK_A);
    drain("post_rst_done");

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 800; c++) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 4) == 0 && fifo_q.size() < 6)
        push({$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    rst       = 1'b0;
    ser_ready = 1'b1;
    drain("random_done");
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
